// File: rtl/bin2therm_dwa.sv
// bin2therm_dwa: registered binary-to-thermometer encoder with optional DWA rotation
module bin2therm_dwa #(
  parameter int NBIT = 5,
  localparam int NELEM = 2**NBIT - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [NBIT-1:0]  in,
  output logic [NELEM-1:0] out,
  output logic             out_valid,
  output logic [NBIT-1:0]  ptr
);
  localparam logic [NBIT:0] NE = (NBIT+1)'(NELEM);
  logic [NELEM-1:0] nxt;
  logic [NBIT:0]    sum;
  logic [NBIT-1:0]  wrap;
  assign sum  = {1'b0, ptr} + {1'b0, in};
  assign wrap = NBIT'(sum >= NE ? sum - NE : sum);
  // element k is on when its distance past ptr (mod NELEM) falls inside the code
  always_comb begin
    nxt = '0;
    for (int k = 0; k < NELEM; k++)
      nxt[k] = mode ? ((k >= int'(ptr) ? k - int'(ptr) : k + NELEM - int'(ptr)) < int'(in))
                    : (k < int'(in));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      out_valid <= en;
      if (en) begin
        out <= nxt;
        ptr <= mode ? wrap : '0;
      end
    end
  end
endmodule

// File: tb/tb_bin2therm_dwa.sv
// tb_bin2therm_dwa: scoreboard bench for bin2therm_dwa (NBIT=5)
module tb_bin2therm_dwa;
  logic        clk = 1'b0;
  logic        rst = 1'b0, en = 1'b0, mode = 1'b0;
  logic [4:0]  in = '0;
  logic [30:0] out;
  logic        out_valid;
  logic [4:0]  ptr;
  int n_run = 0, n_fail = 0;

  typedef struct {logic [30:0] o; logic [4:0] p; logic v;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [30:0] m_out = '0;
  logic [4:0]  m_ptr = '0;
  logic        m_v = 1'b0;

  bin2therm_dwa #(.NBIT(5)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in),
    .out(out), .out_valid(out_valid), .ptr(ptr)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] rot(input logic [30:0] t, input logic [4:0] p);
    logic [61:0] d;
    d = {t, t} >> (31 - int'(p));
    return d[30:0];
  endfunction

  // drive one edge, push the model's expectation, sample #1 after the edge
  task automatic step(input logic r, input logic e_, input logic md, input logic [4:0] c);
    logic [31:0] t32;
    rst = r; en = e_; mode = md; in = c;
    t32 = (32'd1 << c) - 32'd1;
    if (r) begin
      m_out = '0; m_ptr = '0; m_v = 1'b0;
    end else begin
      m_v = e_;
      if (e_) begin
        m_out = md ? rot(t32[30:0], m_ptr) : t32[30:0];
        m_ptr = md ? 5'((int'(m_ptr) + int'(c)) % 31) : 5'd0;
      end
    end
    q.push_back('{m_out, m_ptr, m_v});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 5'd7);
    e = q.pop_front();
    n_run++;
    if (out !== 31'd0 || ptr !== 5'd0 || out_valid !== 1'b0 || out !== e.o) begin
      n_fail++;
      $display("FAIL reset: out=%h ptr=%0d v=%b, required out=0 ptr=0 v=0", out, ptr, out_valid);
    end
  endtask

  task automatic test_therm_sweep();
    logic [31:0] x;
    step(1'b1, 1'b0, 1'b0, 5'd0); void'(q.pop_front());
    for (int c = 0; c < 32; c++) begin
      step(1'b0, 1'b1, 1'b0, 5'(c));
      e = q.pop_front();
      x = (32'd1 << c) - 32'd1;
      n_run++;
      if (out !== x[30:0] || ptr !== 5'd0 || out_valid !== 1'b1 || out !== e.o) begin
        n_fail++;
        $display("FAIL therm in=%0d: out=%h ptr=%0d v=%b, required out=%h ptr=0 v=1", c, out, ptr, out_valid, x[30:0]);
      end
    end
  endtask

  task automatic run_table(input string nm, input logic [4:0] c[], input logic [30:0] o[], input logic [4:0] p[]);
    step(1'b1, 1'b0, 1'b0, 5'd0); void'(q.pop_front());
    foreach (c[i]) begin
      step(1'b0, 1'b1, 1'b1, c[i]);
      e = q.pop_front();
      n_run++;
      if (out !== o[i] || ptr !== p[i] || out_valid !== 1'b1 || out !== e.o || ptr !== e.p) begin
        n_fail++;
        $display("FAIL %s[%0d] in=%0d: out=%h ptr=%0d v=%b, required out=%h ptr=%0d v=1", nm, i, c[i], out, ptr, out_valid, o[i], p[i]);
      end
    end
  endtask

  task automatic test_dwa_basic();
    run_table("dwa_basic", '{5'd5, 5'd3, 5'd0}, '{31'h1F, 31'hE0, 31'h0}, '{5'd5, 5'd8, 5'd8});
  endtask

  task automatic test_dwa_wrap();
    run_table("dwa_wrap", '{5'd31, 5'd29, 5'd4, 5'd31},
              '{31'h7FFFFFFF, 31'h1FFFFFFF, 31'h60000003, 31'h7FFFFFFF}, '{5'd0, 5'd29, 5'd2, 5'd2});
  endtask

  task automatic test_hold_reset();
    step(1'b1, 1'b0, 1'b0, 5'd0); void'(q.pop_front());
    step(1'b0, 1'b1, 1'b1, 5'd9); void'(q.pop_front());
    step(1'b0, 1'b1, 1'b1, 5'd6); void'(q.pop_front());
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 5'(i + 20));
      e = q.pop_front();
      n_run++;
      if (out !== 31'h7E00 || ptr !== 5'd15 || out_valid !== 1'b0 || out !== e.o) begin
        n_fail++;
        $display("FAIL hold[%0d]: out=%h ptr=%0d v=%b, required out=7e00 ptr=15 v=0", i, out, ptr, out_valid);
      end
    end
    step(1'b1, 1'b1, 1'b1, 5'd7);
    e = q.pop_front();
    n_run++;
    if (out !== 31'd0 || ptr !== 5'd0 || out_valid !== 1'b0 || ptr !== e.p) begin
      n_fail++;
      $display("FAIL midreset: out=%h ptr=%0d v=%b, required out=0 ptr=0 v=0", out, ptr, out_valid);
    end
    step(1'b0, 1'b1, 1'b1, 5'd7);
    e = q.pop_front();
    n_run++;
    if (out !== 31'h7F || ptr !== 5'd7 || out_valid !== 1'b1 || out !== e.o) begin
      n_fail++;
      $display("FAIL after_reset: out=%h ptr=%0d v=%b, required out=7f ptr=7 v=1", out, ptr, out_valid);
    end
  endtask

  task automatic test_mode_switch();
    logic [30:0] o[3] = '{31'hFFF, 31'hF, 31'h3};
    logic [4:0]  p[3] = '{5'd12, 5'd0, 5'd2};
    logic        md[3] = '{1'b1, 1'b0, 1'b1};
    logic [4:0]  c[3] = '{5'd12, 5'd4, 5'd2};
    step(1'b1, 1'b0, 1'b0, 5'd0); void'(q.pop_front());
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, md[i], c[i]);
      e = q.pop_front();
      n_run++;
      if (out !== o[i] || ptr !== p[i] || out_valid !== 1'b1 || ptr !== e.p) begin
        n_fail++;
        $display("FAIL mode_switch[%0d]: out=%h ptr=%0d, required out=%h ptr=%0d", i, out, ptr, o[i], p[i]);
      end
    end
  endtask

  task automatic test_balance();
    int cnt[31];
    int mx, mn;
    foreach (cnt[k]) cnt[k] = 0;
    step(1'b1, 1'b0, 1'b0, 5'd0); void'(q.pop_front());
    for (int i = 0; i < 5000; i++) begin
      step(1'b0, 1'b1, 1'b1, 5'($urandom_range(0, 31)));
      e = q.pop_front();
      n_run++;
      if (out !== e.o || ptr !== e.p || out_valid !== e.v) begin
        n_fail++;
        $display("FAIL balance_model[%0d]: out=%h ptr=%0d v=%b, required out=%h ptr=%0d v=%b", i, out, ptr, out_valid, e.o, e.p, e.v);
      end
      for (int k = 0; k < 31; k++) cnt[k] += (out[k] === 1'b1) ? 1 : 0;
      mx = cnt[0]; mn = cnt[0];
      for (int k = 1; k < 31; k++) begin
        if (cnt[k] > mx) mx = cnt[k];
        if (cnt[k] < mn) mn = cnt[k];
      end
      n_run++;
      if (mx - mn > 1) begin
        n_fail++;
        $display("FAIL balance_spread[%0d]: max-min=%0d, required <=1", i, mx - mn);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_therm_sweep();
    test_dwa_basic();
    test_dwa_wrap();
    test_hold_reset();
    test_mode_switch();
    test_balance();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
